// File: rtl/matrix_transform_pipe.sv
// Streams signed fixed-point 4-vectors through a runtime-loadable 4x4 matrix in 3 stages.
// Optional clamp of each result component is enabled by MATRIX_TRANSFORM_SATURATE_EN.
module matrix_transform_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned FRAC  = 16
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [3:0][WIDTH-1:0] pos,
  input  logic                  valid_in,
  output logic                  ready_out,
  input  logic                  mat_we,
  input  logic [3:0]            mat_addr,
  input  logic [WIDTH-1:0]      mat_data,
  output logic [3:0][WIDTH-1:0] new_pos,
  output logic                  valid_out,
  input  logic                  ready_in
`ifdef MATRIX_TRANSFORM_SATURATE_EN
  ,
  output logic                  sat_flag
`endif
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned SW = 2 * WIDTH + 2;
  localparam logic [WIDTH-1:0]     ONE     = WIDTH'(1) << FRAC;
  localparam logic signed [SW-1:0] RND     = SW'(1) << (FRAC - 1);
  localparam logic signed [SW-1:0] SAT_MAX = SW'({1'b0, {(WIDTH - 1){1'b1}}});
  localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

  logic [WIDTH-1:0]       mat_q  [16];
  logic                   v1_q, v2_q, v3_q;
  logic signed [PW-1:0]   prod_q [4][4];
  logic signed [PW:0]     psum_q [4][2];
  logic [3:0][WIDTH-1:0]  res_q, res_d;
  logic signed [SW-1:0]   sh     [4];
  logic                   sat_q, sat_d;
  logic                   stall;

  // One global stall: every stage holds while the output is blocked.
  assign stall     = v3_q && !ready_in;
  assign ready_out = !stall;
  assign valid_out = v3_q;
  assign new_pos   = res_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < 16; i++) begin
        mat_q[i] <= (i % 5 == 0) ? ONE : '0;
      end
    end else if (mat_we) begin
      mat_q[mat_addr] <= mat_data;
    end
  end

  // Products are captured at acceptance, so later matrix writes never touch in-flight data.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      v1_q <= 1'b0;
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) begin
          prod_q[r][c] <= '0;
        end
      end
    end else if (!stall) begin
      v1_q <= valid_in;
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) begin
          prod_q[r][c] <= PW'($signed(mat_q[r*4+c])) * PW'($signed(pos[3-c]));
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      v2_q <= 1'b0;
      for (int r = 0; r < 4; r++) begin
        psum_q[r][0] <= '0;
        psum_q[r][1] <= '0;
      end
    end else if (!stall) begin
      v2_q <= v1_q;
      for (int r = 0; r < 4; r++) begin
        psum_q[r][0] <= (PW+1)'(prod_q[r][0]) + (PW+1)'(prod_q[r][1]);
        psum_q[r][1] <= (PW+1)'(prod_q[r][2]) + (PW+1)'(prod_q[r][3]);
      end
    end
  end

  always_comb begin
    res_d = '0;
    sat_d = 1'b0;
    for (int r = 0; r < 4; r++) begin
      sh[r] = (SW'(psum_q[r][0]) + SW'(psum_q[r][1]) + RND) >>> FRAC;
`ifdef MATRIX_TRANSFORM_SATURATE_EN
      if (sh[r] > SAT_MAX) begin
        res_d[3-r] = SAT_MAX[WIDTH-1:0];
        sat_d      = 1'b1;
      end else if (sh[r] < SAT_MIN) begin
        res_d[3-r] = SAT_MIN[WIDTH-1:0];
        sat_d      = 1'b1;
      end else begin
        res_d[3-r] = sh[r][WIDTH-1:0];
      end
`else
      res_d[3-r] = sh[r][WIDTH-1:0];
`endif
    end
  end

`ifdef MATRIX_TRANSFORM_SATURATE_EN
  assign sat_flag = sat_q;
`else
  // Wrapping keeps only the low bits of the shifted sum.
  logic unused_hi;
  assign unused_hi = ^{sh[0][SW-1:WIDTH], sh[1][SW-1:WIDTH], sh[2][SW-1:WIDTH],
                       sh[3][SW-1:WIDTH], sat_d, sat_q, SAT_MIN[0]};
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      v3_q  <= 1'b0;
      res_q <= '0;
      sat_q <= 1'b0;
    end else if (!stall) begin
      v3_q  <= v2_q;
      res_q <= res_d;
      sat_q <= sat_d;
    end
  end

endmodule

// File: tb/tb_matrix_transform_pipe.sv
// Self-checking bench: directed steps plus random traffic against a queue-based reference model.
module tb_matrix_transform_pipe;

  typedef struct {
    logic [3:0][31:0] v;
    logic             sat;
  } exp_t;

  logic             clk_in = 1'b0;
  logic             rst_in, valid_in, ready_out, mat_we, valid_out, ready_in;
  logic [3:0][31:0] pos, new_pos;
  logic [3:0]       mat_addr;
  logic [31:0]      mat_data;
`ifdef MATRIX_TRANSFORM_SATURATE_EN
  logic             sat_flag;
`endif

  int               checks = 0;
  int               errors = 0;
  logic [31:0]      mdl [16];
  exp_t             exp_q [$];
  logic             last_acc;

  matrix_transform_pipe #(.WIDTH(32), .FRAC(16)) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .pos       (pos),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .mat_we    (mat_we),
    .mat_addr  (mat_addr),
    .mat_data  (mat_data),
    .new_pos   (new_pos),
    .valid_out (valid_out),
    .ready_in  (ready_in)
`ifdef MATRIX_TRANSFORM_SATURATE_EN
    ,
    .sat_flag  (sat_flag)
`endif
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_identity();
    for (int i = 0; i < 16; i++) mdl[i] = (i % 5 == 0) ? 32'h0001_0000 : 32'h0;
  endtask

  // Exact dot product, then round half up on the 16 discarded bits.
  function automatic logic [31:0] ref_comp(input int r, input logic [3:0][31:0] v,
                                           output logic sat);
    logic signed [79:0] acc, q;
    acc = '0;
    for (int c = 0; c < 4; c++) acc += 80'($signed(mdl[r*4+c])) * 80'($signed(v[3-c]));
    q = acc >>> 16;
    if (acc[15]) q = q + 1;
    sat = 1'b0;
`ifdef MATRIX_TRANSFORM_SATURATE_EN
    if (q > 80'sd2147483647) begin
      sat = 1'b1;
      return 32'h7FFF_FFFF;
    end
    if (q < -80'sd2147483648) begin
      sat = 1'b1;
      return 32'h8000_0000;
    end
`endif
    return q[31:0];
  endfunction

  function automatic exp_t model(input logic [3:0][31:0] v);
    exp_t e;
    logic s;
    e.sat = 1'b0;
    for (int r = 0; r < 4; r++) begin
      e.v[3-r] = ref_comp(r, v, s);
      e.sat |= s;
    end
    return e;
  endfunction

  // One clock cycle with the inputs currently driven; scores transfers and stall holds.
  task automatic tick();
    exp_t             e;
    logic             stalled;
    logic [3:0][31:0] held;
    #1;
    check("ready_rule", ready_out, !(valid_out && !ready_in));
    stalled  = valid_out && !ready_in;
    held     = new_pos;
    last_acc = valid_in && ready_out && !rst_in;
    if (!rst_in) begin
      if (valid_out && ready_in) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", valid_out, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("new_pos", new_pos, e.v);
`ifdef MATRIX_TRANSFORM_SATURATE_EN
          check("sat_flag", sat_flag, e.sat);
`endif
        end
      end
      if (valid_in && ready_out) exp_q.push_back(model(pos));
      if (mat_we) mdl[mat_addr] = mat_data;
    end
    @(posedge clk_in);
    #1;
    if (rst_in) begin
      exp_q.delete();
      model_identity();
      check("rst_valid", valid_out, 1'b0);
    end else if (stalled) begin
      check("stall_valid", valid_out, 1'b1);
      check("stall_hold", new_pos, held);
    end
  endtask

  task automatic write_m(input logic [3:0] a, input logic [31:0] d);
    mat_we = 1'b1; mat_addr = a; mat_data = d;
    tick();
    mat_we = 1'b0;
  endtask

  task automatic send_one(input logic [3:0][31:0] v, output logic [3:0][31:0] got);
    int n;
    pos = v; valid_in = 1'b1; ready_in = 1'b1;
    tick();
    valid_in = 1'b0; mat_we = 1'b0;
    n = 0;
    while (!valid_out && n < 10) begin
      tick();
      n++;
    end
    check("latency", n, 2);
    got = new_pos;
    tick();
    check("single_pulse", valid_out, 1'b0);
  endtask

  task automatic drain();
    int n;
    valid_in = 1'b0; ready_in = 1'b1; n = 0;
    while (exp_q.size() > 0 && n < 20) begin
      tick();
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    logic [3:0][31:0] v1, got, rv;
    logic [3:0][31:0] vecs [8];
    int               idx;

    rst_in = 1'b1; valid_in = 1'b0; ready_in = 1'b1; mat_we = 1'b0;
    mat_addr = '0; mat_data = '0; pos = '0;
    model_identity();
    tick();
    tick();
    rst_in = 1'b0;
    check("reset_valid_out", valid_out, 1'b0);
    check("reset_new_pos", new_pos, '0);
    check("reset_ready_out", ready_out, 1'b1);

    // Identity pass-through with 3-cycle latency.
    v1 = {32'h0001_0000, 32'h0001_0000, 32'h0, 32'h0001_0000};
    send_one(v1, got);
    check("identity", got, v1);

    // Write in the acceptance cycle uses the old matrix; the next vector sees the new one.
    mat_we = 1'b1; mat_addr = 4'd3; mat_data = 32'h0002_0000;
    send_one(v1, got);
    check("write_same_cycle_x", got[3], 32'h0001_0000);
    send_one(v1, got);
    check("write_new_x", got[3], 32'h0003_0000);
    check("write_new_yzw", got[2:0], v1[2:0]);

    // Random matrix, 8 back-to-back vectors, output blocked on cycles 4-6.
    for (int i = 0; i < 16; i++) write_m(4'(i), $urandom);
    for (int i = 0; i < 8; i++) vecs[i] = {$urandom, $urandom, $urandom, $urandom};
    idx = 0;
    for (int cyc = 0; cyc < 40 && (idx < 8 || exp_q.size() > 0); cyc++) begin
      ready_in = !(cyc >= 4 && cyc <= 6);
      valid_in = (idx < 8);
      pos      = vecs[idx % 8];
      tick();
      if (last_acc) idx++;
    end
    check("stream_all_sent", idx, 8);
    drain();

    // Rounding: 0.5 * (+1 LSB) -> 1, 0.5 * (-1 LSB) -> 0.
    for (int i = 0; i < 16; i++) write_m(4'(i), (i % 5 == 0) ? 32'h0001_0000 : 32'h0);
    write_m(4'd0, 32'h0000_8000);
    send_one({32'h1, 32'h0, 32'h0, 32'h0}, got);
    check("round_pos_half", got[3], 32'h1);
    send_one({32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0}, got);
    check("round_neg_half", got[3], 32'h0);

    // Overflow: 0x7FFF.0 * 2.0.
    write_m(4'd0, 32'h7FFF_0000);
    send_one({32'h0002_0000, 32'h0, 32'h0, 32'h0}, got);
`ifdef MATRIX_TRANSFORM_SATURATE_EN
    check("overflow_sat", got[3], 32'h7FFF_FFFF);
`else
    check("overflow_wrap", got[3], 32'hFFFE_0000);
`endif

    // Random traffic with random backpressure and matrix writes, including during stalls.
    for (int cyc = 0; cyc < 300; cyc++) begin
      valid_in = ($urandom_range(0, 3) != 0);
      ready_in = ($urandom_range(0, 3) != 0);
      pos      = {$urandom, $urandom, $urandom, $urandom};
      mat_we   = ($urandom_range(0, 7) == 0);
      mat_addr = 4'($urandom);
      mat_data = $urandom;
      tick();
    end
    mat_we = 1'b0;
    drain();

    // Reset with two vectors in flight and a non-identity matrix.
    write_m(4'd0, 32'h0003_0000);
    write_m(4'd6, 32'hFFFF_0000);
    valid_in = 1'b1; ready_in = 1'b1;
    pos = {$urandom, $urandom, $urandom, $urandom};
    tick();
    pos = {$urandom, $urandom, $urandom, $urandom};
    tick();
    valid_in = 1'b0; rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("post_reset_quiet", valid_out, 1'b0);
    end
    rv = {$urandom, $urandom, $urandom, $urandom};
    send_one(rv, got);
    check("post_reset_identity", got, rv);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/matrix_transform_pipe.md
Name: matrix_transform_pipe

Overview:
- Parametrised successor to the fixed vertex transformation stage.
- Multiplies a streamed homogeneous 4-vector (x,y,z,w) by a runtime-loadable 4x4 matrix in signed fixed point.
- Sits between vertex fetch and projection/rasterisation.
- Adds programmable matrix, width/fraction parameters, valid/ready backpressure and rounding.

Parameters:
- WIDTH, 32, total bits per component (signed two's complement).
- FRAC, 16, fractional bits; Q(WIDTH-FRAC).FRAC format; 1 <= FRAC < WIDTH.

Ports:
- clk_in  input  1  clock.
- rst_in  input  1  synchronous active-high reset.
- pos  input  [3:0][WIDTH]  input vector; pos[3]=x, pos[2]=y, pos[1]=z, pos[0]=w.
- valid_in  input  1  pos valid.
- ready_out  output  1  block can accept pos this cycle.
- mat_we  input  1  matrix element write strobe.
- mat_addr  input  4  element index = row*4+col.
- mat_data  input  WIDTH  element value.
- new_pos  output  [3:0][WIDTH]  result, same component ordering as pos.
- valid_out  output  1  new_pos valid.
- ready_in  input  1  downstream accepts new_pos.

Behaviour:
- Clock is clk_in only; rst_in is synchronous, active-high; every register is reset on the clk_in edge with rst_in=1.
- Reset values:
  - valid_out=0; new_pos=0; all pipeline valids=0.
  - Matrix = identity: diagonal = 1<<FRAC, all other elements 0.
  - ready_out=1 in the first cycle after reset.
- Matrix indexing:
  - Row r produces output component r (r=0 -> x -> new_pos[3] … r=3 -> w -> new_pos[0]).
  - Column c multiplies input component c (c=0 -> pos[3] … c=3 -> pos[0]).
- Matrix write: on mat_we, M[mat_addr] <= mat_data at the clock edge.
  - A vector accepted in the same cycle as a write uses the old matrix.
  - Vectors accepted from the next cycle onward use the new value.
  - Vectors already in flight are unaffected; products are captured at acceptance.
- Pipeline: 3 stages, latency 3 cycles from accept to valid_out when unstalled; throughput 1 vector/cycle.
  - S1: 16 signed products, each 2*WIDTH bits, registered.
  - S2: pairwise sums per row (2*WIDTH+1 bits).
  - S3: row sum (2*WIDTH+2 bits) + rounding constant (1<<(FRAC-1)), arithmetic shift right by FRAC, reduce to WIDTH, register into new_pos.
- Rounding: round-half-up toward +inf on the discarded fraction (e.g. -0.5 LSB rounds to 0).
- Handshakes:
  - Accept when valid_in && ready_out.
  - Output transfer when valid_out && ready_in.
  - stall = valid_out && !ready_in. While stalled all stages hold and ready_out=0.
  - Bubbles do not collapse; a global stall is sufficient.
  - ready_out = !stall, combinational.
  - new_pos and valid_out stay stable while stalled.
  - pos is ignored when not accepted.
- Simultaneous events:
  - Output transfer and new accept in the same cycle are both honoured.
  - mat_we is honoured even during a stall.
- Reset mid-operation: all in-flight vectors are discarded, valid_out drops to 0 the next cycle, and the matrix returns to identity.
- Overflow without SATURATE_EN: keep the low WIDTH bits of the shifted sum (wrap).

Optional Feature:
- Macro: MATRIX_TRANSFORM_SATURATE_EN.
- Defined: in S3, a shifted sum above 2^(WIDTH-1)-1 clamps to that value, and one below -2^(WIDTH-1) clamps to -2^(WIDTH-1).
  - Adds output port sat_flag (1 bit), registered alongside new_pos. It is 1 if any component of that result clamped, and it resets to 0.
- Undefined: the wrap behaviour applies and the sat_flag port does not exist.

Test Plan (WIDTH=32, FRAC=16, 1.0=0x00010000):
- Reset, then pos=(x=0x00010000, y=0x00010000, z=0, w=0x00010000), valid_in=1 for one cycle, ready_in=1 -> valid_out exactly 3 cycles later for one cycle with new_pos equal to the input.
- Write M[3] (row0,col3) = 0x00020000, then send the same vector -> x=0x00030000, y/z/w unchanged. A vector accepted in the write cycle still yields x=0x00010000.
- Back-to-back stream of 8 vectors with ready_in low for cycles 4-6:
  - ready_out low during the stall.
  - No vector lost or duplicated.
  - Outputs in order and stable while stalled.
- Rounding with M[0]=0x00008000 (0.5):
  - x=0x00000001 -> x_out=0x00000001 (0.5 LSB rounds up).
  - x=0xFFFFFFFF -> x_out=0x00000000.
- Overflow with M[0]=0x7FFF0000 and x=0x00020000:
  - Macro undefined -> wrapped low 32 bits (0xFFFE0000).
  - Macro defined -> 0x7FFFFFFF with sat_flag=1.
- Assert rst_in for one cycle with 2 vectors in flight and a non-identity matrix -> no valid_out afterwards; next vector passes through unchanged (identity restored).
